alu_core: RTL and testbench

- 4-bit registered ALU for the Proyecto4 datapath.
- Takes two 4-bit operands and a 3-bit function select, and computes one of eight operations.
- Result and carry/zero/negative flags are registered on the rising clock edge.
- Sits between the operand register file and the result/flag consumers; operands and function change freely every cycle.

---
 rtl/alu_core.sv | 99 +++++++++
 tb/tb_alu_core.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// alu_core: 4-bit registered ALU for the Proyecto4 datapath.
//
// Computes one of eight operations from two operands and a function select.
// The result and its carry/zero/negative flags are captured together on the
// rising clock edge, giving a fixed one-cycle latency with a new result
// every cycle.
//
// Ports:
//   clk       in   system clock, rising-edge active
//   rst_n     in   asynchronous reset, active-low; clears all outputs
//   operA     in   [WIDTH-1:0] first operand (unsigned)
//   operB     in   [WIDTH-1:0] second operand (unsigned)
//   alu_fun   in   [2:0] operation select
//                  0 pass A, 1 add, 2 sub, 3 shl B, 4 and, 5 or, 6 xor, 7 pass B
//   result    out  [WIDTH-1:0] registered result
//   carry     out  registered carry / borrow / shift-out flag
//   zero      out  registered flag, 1 when result is all zeros
//   negative  out  registered copy of the result MSB
module alu_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] operA,
  input  logic [WIDTH-1:0] operB,
  input  logic [2:0]       alu_fun,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative
);

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;
  logic             negative_d, negative_q;

  // Zero-extended operands so the extra top bit of add/sub holds the
  // carry-out or the borrow.
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  assign sum_ext  = {1'b0, operA} + {1'b0, operB};
  assign diff_ext = {1'b0, operA} - {1'b0, operB};

  always_comb begin
    result_d = operA;
    carry_d  = 1'b0;
    unique case (alu_fun)
      3'd0: result_d = operA;
      3'd1: begin
        result_d = sum_ext[WIDTH-1:0];
        carry_d  = sum_ext[WIDTH];
      end
      3'd2: begin
        // Top bit of the wrapped (WIDTH+1)-bit difference is set exactly
        // when operA < operB, i.e. a borrow occurred.
        result_d = diff_ext[WIDTH-1:0];
        carry_d  = diff_ext[WIDTH];
      end
      3'd3: begin
        result_d = {operB[WIDTH-2:0], 1'b0};
        carry_d  = operB[WIDTH-1];
      end
      3'd4: result_d = operA & operB;
      3'd5: result_d = operA | operB;
      3'd6: result_d = operA ^ operB;
      3'd7: result_d = operB;
      default: begin
        result_d = operA;
        carry_d  = 1'b0;
      end
    endcase
    zero_d     = (result_d == '0);
    negative_d = result_d[WIDTH-1];
  end

  // All outputs share one register stage so result and flags always
  // change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign negative = negative_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: self-checking bench for alu_core.
//
// Directed vectors cover reset behaviour and the arithmetic/logic boundary
// cases; a randomized run changes inputs every cycle and compares each
// registered output against an arithmetic reference model of the previous
// cycle's inputs. Outputs are packed as {result, carry, zero, negative}.
module tb_alu_core;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] operA;
  logic [WIDTH-1:0] operB;
  logic [2:0]       alu_fun;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             negative;

  int checks;
  int errors;

  alu_core #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .operA    (operA),
    .operB    (operB),
    .alu_fun  (alu_fun),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .negative (negative)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [WIDTH+2:0] packOut(input int res, input int c,
                                               input int z, input int n);
    logic [WIDTH+2:0] p;
    p = {res[WIDTH-1:0], c[0], z[0], n[0]};
    return p;
  endfunction

  // Reference model written directly from the operation rules using
  // integer arithmetic on the unsigned operand values.
  function automatic logic [WIDTH+2:0] modelAlu(input int a, input int b, input int f);
    int modv;
    int res;
    int c;
    modv = 1 << WIDTH;
    c    = 0;
    case (f)
      1: begin
        res = (a + b) % modv;
        c   = (a + b >= modv) ? 1 : 0;
      end
      2: begin
        res = (a - b + modv) % modv;
        c   = (a < b) ? 1 : 0;
      end
      3: begin
        res = (b * 2) % modv;
        c   = (b >= modv / 2) ? 1 : 0;
      end
      4: res = a & b;
      5: res = a | b;
      6: res = a ^ b;
      7: res = b;
      default: res = a;
    endcase
    return packOut(res, c, (res == 0) ? 1 : 0, (res >= modv / 2) ? 1 : 0);
  endfunction

  function automatic logic [WIDTH+2:0] observed();
    return {result, carry, zero, negative};
  endfunction

  task automatic checkOutput(input string tag, input logic [WIDTH+2:0] obs,
                             input logic [WIDTH+2:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got res=%0d c=%0b z=%0b n=%0b, required res=%0d c=%0b z=%0b n=%0b",
               tag, obs[WIDTH+2:3], obs[2], obs[1], obs[0],
               exp[WIDTH+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive new inputs on the falling edge, then sample just after the
  // following rising edge.
  task automatic applyStimulus(input int a, input int b, input int f);
    @(negedge clk);
    operA   = a[WIDTH-1:0];
    operB   = b[WIDTH-1:0];
    alu_fun = f[2:0];
    @(posedge clk);
    #1;
  endtask

  int dir_a[18]   = '{1, 0, 15, 8, 4, 1, 1, 10, 10, 10, 5, 1, 5, 1, 5, 1, 9, 9};
  int dir_b[18]   = '{1, 0, 15, 8, 2, 1, 10, 3, 1, 10, 10, 1, 10, 1, 10, 1, 3, 3};
  int dir_f[18]   = '{1, 1, 1, 1, 1, 2, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 0, 7};
  int dir_res[18] = '{2, 0, 14, 0, 6, 0, 7, 7, 2, 4, 0, 1, 15, 1, 15, 0, 9, 3};
  int dir_c[18]   = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  int dir_z[18]   = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
  int dir_n[18]   = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    logic [WIDTH+2:0] prev_exp;
    int a, b, f;

    checks = 0;
    errors = 0;

    // Reset held with live inputs and a running clock.
    rst_n   = 1'b0;
    operA   = 4'd15;
    operB   = 4'd15;
    alu_fun = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold", observed(), packOut(0, 0, 0, 0));

    // First update happens on the first rising edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release", observed(), packOut(14, 1, 0, 1));

    // Directed boundary vectors against hand-derived expectations.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(dir_a[i], dir_b[i], dir_f[i]);
      checkOutput($sformatf("dir%0d_f%0d_%0d_%0d", i, dir_f[i], dir_a[i], dir_b[i]),
                  observed(), packOut(dir_res[i], dir_c[i], dir_z[i], dir_n[i]));
    end

    // Randomized run: inputs change every cycle. Between edges the
    // outputs must still show the previous inputs' result.
    prev_exp = packOut(dir_res[17], dir_c[17], dir_z[17], dir_n[17]);
    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      f = int'($urandom_range(7, 0));
      @(negedge clk);
      operA   = a[WIDTH-1:0];
      operB   = b[WIDTH-1:0];
      alu_fun = f[2:0];
      #1;
      checkOutput($sformatf("hold%0d", i), observed(), prev_exp);
      @(posedge clk);
      #1;
      prev_exp = modelAlu(a, b, f);
      checkOutput($sformatf("rand%0d_f%0d_%0d_%0d", i, f, a, b), observed(), prev_exp);
    end

    // Reset asserted mid-cycle clears outputs without a clock edge.
    applyStimulus(15, 15, 1);
    checkOutput("pre_midreset", observed(), packOut(14, 1, 0, 1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_async", observed(), packOut(0, 0, 0, 0));
    @(posedge clk);
    #1;
    checkOutput("midreset_held", observed(), packOut(0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8, 8, 1);
    checkOutput("post_midreset", observed(), packOut(0, 1, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
